// File: rtl/bip_fetch_decode.sv
// BIP fetch/decode: owns the program counter and turns each instruction word into datapath strobes.
// Optional build macro BIP_CYCLE_COUNT_EN adds a saturating 32-bit count of executed RUN cycles.
module bip_fetch_decode #(
    parameter int PC_WIDTH     = 11,
    parameter int DATA_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] instr_data,
    output logic [PC_WIDTH-1:0]   pc_addr,
    output logic [PC_WIDTH-1:0]   operand,
    output logic                  wr_acc,
    output logic [1:0]            sel_a,
    output logic                  sel_b,
    output logic                  op_sub,
    output logic                  wr_ram,
    output logic                  rd_ram,
    output logic                  halted,
`ifdef BIP_CYCLE_COUNT_EN
    output logic [31:0]           cycle_count,
`endif
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);

    state_t                  state, state_next;
    logic [PC_WIDTH-1:0]     pc_next;
    logic [OPCODE_WIDTH-1:0] opcode;

    assign opcode    = instr_data[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign fsm_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc_addr <= '0;
            halted  <= 1'b0;
        end else begin
            state   <= state_next;
            pc_addr <= pc_next;
            halted  <= (state_next == HALT);
        end
    end

    // enable only qualifies RUN: it is a run/stall input, not a handshake.
    // Strobes are decoded only inside RUN so an undefined word in IDLE/HALT never reaches them.
    always_comb begin
        state_next = state;
        pc_next    = pc_addr;
        operand    = '0;
        wr_acc     = 1'b0;
        sel_a      = 2'b00;
        sel_b      = 1'b0;
        op_sub     = 1'b0;
        wr_ram     = 1'b0;
        rd_ram     = 1'b0;
        case (state)
            IDLE: state_next = RUN;
            RUN: begin
                operand = instr_data[PC_WIDTH-1:0];
                if (enable) begin
                    if (opcode == OP_HLT) begin
                        state_next = HALT;
                    end else begin
                        pc_next = pc_addr + PC_WIDTH'(1);
                    end
                    case (opcode)
                        OP_STO:  wr_ram = 1'b1;
                        OP_LD: begin
                            rd_ram = 1'b1;
                            wr_acc = 1'b1;
                        end
                        OP_LDI: begin
                            wr_acc = 1'b1;
                            sel_a  = 2'b01;
                        end
                        OP_ADD: begin
                            rd_ram = 1'b1;
                            wr_acc = 1'b1;
                            sel_a  = 2'b10;
                        end
                        OP_ADDI: begin
                            wr_acc = 1'b1;
                            sel_a  = 2'b10;
                            sel_b  = 1'b1;
                        end
                        OP_SUB: begin
                            rd_ram = 1'b1;
                            wr_acc = 1'b1;
                            sel_a  = 2'b10;
                            op_sub = 1'b1;
                        end
                        OP_SUBI: begin
                            wr_acc = 1'b1;
                            sel_a  = 2'b10;
                            sel_b  = 1'b1;
                            op_sub = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

`ifdef BIP_CYCLE_COUNT_EN
    // Counts every enabled RUN edge, the HLT edge included; sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (state == RUN && enable && cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bip_fetch_decode.sv
// Bench for bip_fetch_decode: behavioural program memory, per-cycle expected queue and monitor.
module tb_bip_fetch_decode;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] instr_data = '0;
    logic [10:0] pc_addr, operand;
    logic        wr_acc, sel_b, op_sub, wr_ram, rd_ram, halted;
    logic [1:0]  sel_a, fsm_state;
`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    logic [15:0] mem [0:2047];
    logic [31:0] exp_q[$];
    logic [31:0] p1_exp [0:6];
    logic [31:0] p2_exp [0:4];
    logic        chk_en = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          win_no = 0;

    bip_fetch_decode dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .instr_data (instr_data),
        .pc_addr    (pc_addr),
        .operand    (operand),
        .wr_acc     (wr_acc),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .op_sub     (op_sub),
        .wr_ram     (wr_ram),
        .rd_ram     (rd_ram),
        .halted     (halted),
`ifdef BIP_CYCLE_COUNT_EN
        .cycle_count(cycle_count),
`endif
        .fsm_state  (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // program memory presents the addressed word on the falling edge
    always @(negedge clk) instr_data = mem[pc_addr];

    function automatic logic [31:0] mk(input logic [1:0] st, input logic h, input logic [10:0] pc,
                                       input logic [10:0] opd, input logic wa, input logic [1:0] sa,
                                       input logic sb, input logic os, input logic wr, input logic rr);
        return {st, h, pc, opd, wa, sa, sb, os, wr, rr};
    endfunction

    // driver: one call per cycle, inputs set 1 time unit after the falling edge
    task automatic win(input logic rst, input logic en, input logic [31:0] e);
        @(negedge clk);
        #1;
        reset  = rst;
        enable = en;
        exp_q.push_back(e);
        chk_en = 1'b1;
    endtask

`ifdef BIP_CYCLE_COUNT_EN
    task automatic check_cc(input logic [31:0] e);
        #3;
        total++;
        if (cycle_count !== e) begin
            bad++;
            $display("FAIL cycle_count got=%0d exp=%0d", cycle_count, e);
        end
    endtask
`endif

    // monitor / scoreboard: sample mid-way between falling and rising edge
    always begin
        logic [31:0] got, e;
        @(negedge clk);
        #3;
        if (chk_en) begin
            got = {fsm_state, halted, pc_addr, operand, wr_acc, sel_a, sel_b, op_sub, wr_ram, rd_ram};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL underflow win=%0d got=%h", win_no, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL win=%0d got=%h exp=%h (st,h,pc,opd,wa,sa,sb,os,wr,rr)", win_no, got, e);
                end
            end
            win_no++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] idle_e, halt1_e, pause_e, halt2_e;
        logic [10:0] a;
        idle_e  = mk(S_IDLE, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        halt1_e = mk(S_HALT, 1, 6, 0, 0, 2'b00, 0, 0, 0, 0);
        halt2_e = mk(S_HALT, 1, 4, 0, 0, 2'b00, 0, 0, 0, 0);
        pause_e = mk(S_RUN,  0, 3, 255, 0, 2'b00, 0, 0, 0, 0);

        // program 1: LDI 16 / STO 1 / LD 1 / ADDI 255 / STO 2 / LD 2 / HLT
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        mem[0] = {5'b00011, 11'd16};
        mem[1] = {5'b00001, 11'd1};
        mem[2] = {5'b00010, 11'd1};
        mem[3] = {5'b00101, 11'd255};
        mem[4] = {5'b00001, 11'd2};
        mem[5] = {5'b00010, 11'd2};
        mem[6] = {5'b00000, 11'd0};
        p1_exp[0] = mk(S_RUN, 0, 0, 16,  1, 2'b01, 0, 0, 0, 0);
        p1_exp[1] = mk(S_RUN, 0, 1, 1,   0, 2'b00, 0, 0, 1, 0);
        p1_exp[2] = mk(S_RUN, 0, 2, 1,   1, 2'b00, 0, 0, 0, 1);
        p1_exp[3] = mk(S_RUN, 0, 3, 255, 1, 2'b10, 1, 0, 0, 0);
        p1_exp[4] = mk(S_RUN, 0, 4, 2,   0, 2'b00, 0, 0, 1, 0);
        p1_exp[5] = mk(S_RUN, 0, 5, 2,   1, 2'b00, 0, 0, 0, 1);
        p1_exp[6] = mk(S_RUN, 0, 6, 0,   0, 2'b00, 0, 0, 0, 0);
        // program 2: ADD 3 / SUB 4 / SUBI 5 / NOP(11111) 2047 / HLT with nonzero operand
        p2_exp[0] = mk(S_RUN, 0, 0, 3,      1, 2'b10, 0, 0, 0, 1);
        p2_exp[1] = mk(S_RUN, 0, 1, 4,      1, 2'b10, 0, 1, 0, 1);
        p2_exp[2] = mk(S_RUN, 0, 2, 5,      1, 2'b10, 1, 1, 0, 0);
        p2_exp[3] = mk(S_RUN, 0, 3, 11'h7FF, 0, 2'b00, 0, 0, 0, 0);
        p2_exp[4] = mk(S_RUN, 0, 4, 11'h155, 0, 2'b00, 0, 0, 0, 0);

        // reset state, then release: IDLE must gate the LDI already on the bus
        win(1, 0, idle_e);
        win(1, 1, idle_e);
`ifdef BIP_CYCLE_COUNT_EN
        check_cc(0);
`endif
        win(0, 1, idle_e);
        for (int i = 0; i < 7; i++) win(0, 1, p1_exp[i]);
        win(0, 1, halt1_e);
`ifdef BIP_CYCLE_COUNT_EN
        check_cc(7);
`endif
        for (int i = 0; i < 10; i++) win(0, 1, halt1_e);
`ifdef BIP_CYCLE_COUNT_EN
        check_cc(7);
`endif

        // rerun with a 3-cycle stall at pc 3, then async reset at pc 4
        win(1, 1, idle_e);
`ifdef BIP_CYCLE_COUNT_EN
        check_cc(0);
`endif
        win(0, 1, idle_e);
        for (int i = 0; i < 3; i++) win(0, 1, p1_exp[i]);
        for (int i = 0; i < 3; i++) win(0, 0, pause_e);
        win(0, 1, p1_exp[3]);
        win(1, 1, idle_e);
        win(0, 1, idle_e);
        win(0, 1, p1_exp[0]);
        win(0, 1, p1_exp[1]);

        // reset and swap in program 2 while reset is held
        win(1, 1, idle_e);
        mem[0] = {5'b00100, 11'd3};
        mem[1] = {5'b00110, 11'd4};
        mem[2] = {5'b00111, 11'd5};
        mem[3] = {5'b11111, 11'h7FF};
        mem[4] = {5'b00000, 11'h155};
        win(0, 1, idle_e);
        for (int i = 0; i < 5; i++) win(0, 1, p2_exp[i]);
        for (int i = 0; i < 3; i++) win(0, 1, halt2_e);

        // all-NOP memory: PC runs through 2047 and wraps to 0
        win(1, 1, idle_e);
        for (int i = 0; i < 2048; i++) begin
            a = i[10:0];
            mem[i] = {5'b01010, a};
        end
        win(0, 1, idle_e);
        for (int i = 0; i < 2050; i++) begin
            a = i[10:0];
            win(0, 1, mk(S_RUN, 0, a, a, 0, 2'b00, 0, 0, 0, 0));
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        #5;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
